mod_counter: RTL
================

Name: mod_counter

Overview:
Parametrised successor to the 4-bit free-running counter. Counts modulo MODULO, up or down, with a built-in enable prescaler, synchronous load and soft clear, and wrap or saturate limit mode. Outputs a terminal-count pulse and a compare match. Used as the generic step/timing counter in the cube datapath, for example move sequencing and display refresh.

Parameters:
WIDTH, 8, counter width in bits; legal range 2..16
MODULO, 10, count range is 0..MODULO-1; legal range 2..2**WIDTH
PRESCALE, 1, number of qualified ena pulses per count step; legal range 1..256
SATURATE, 0, 0 = wrap at the limits, 1 = hold at the limits

Ports:
clkf  in  1  system clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset
ena  in  1  count enable, sampled every cycle
up_dn  in  1  1 = count up, 0 = count down; sampled only on a step cycle
clear  in  1  synchronous soft clear
load  in  1  synchronous parallel load
load_val  in  WIDTH  value to load
cmp_val  in  WIDTH  compare value
count  out  WIDTH  current count, registered
tc  out  1  terminal-count pulse, registered
match  out  1  combinational; high when count == cmp_val
at_max  out  1  combinational; high when count == MODULO-1
at_min  out  1  combinational; high when count == 0

Behaviour:
- Reset: when rst=1 at a clkf edge: count=0, tc=0, prescaler=0. rst overrides every other input.
- Priority per edge: rst > clear > load > step.
- clear=1: count=0, prescaler=0, tc=0.
- load=1: count = load_val if load_val < MODULO, else MODULO-1 (clamped). Prescaler=0, tc=0. load never produces a tc pulse.
- Prescaler:
  - Internal counter of width clog2(PRESCALE), minimum 1 bit.
  - A step occurs when ena=1 and prescaler == PRESCALE-1; the prescaler then returns to 0.
  - When ena=1 with no step, the prescaler increments.
  - When ena=0, the prescaler holds.
  - With PRESCALE=1, every ena=1 cycle is a step.
- Step, up (up_dn=1):
  - count < MODULO-1: count+1.
  - count == MODULO-1: wrap to 0 if SATURATE=0; hold if SATURATE=1.
- Step, down (up_dn=0):
  - count > 0: count-1.
  - count == 0: wrap to MODULO-1 if SATURATE=0; hold if SATURATE=1.
- tc:
  - High for exactly one cycle after a step taken while count was already at the limit in the step direction (MODULO-1 going up, 0 going down).
  - This applies in both modes. In saturate mode, tc repeats on every further step at the limit.
  - Otherwise tc=0 on every edge.
- Latency: count and tc change on the same edge that qualifies the step. match, at_max and at_min follow count combinationally, with no added latency.
- Direction change takes effect on the next step, with no extra cycle. The prescaler phase is kept across a direction change.
- No out-of-range state: count never exceeds MODULO-1, including after load. Arithmetic is unsigned WIDTH-bit, with no overflow past MODULO-1.
- Reset or clear mid-prescale discards the partial prescale count.

Test Plan:
1. Reset and wrap (WIDTH=4, MODULO=10, PRESCALE=1): rst for 2 cycles, then ena=1, up_dn=1 for 12 cycles -> count sequence 0,1..9,0,1; tc high exactly the cycle after count goes 9->0; at_max high while count=9.
2. Down wrap and saturate (MODULO=10): load 0, then down for 2 steps -> with SATURATE=0: 9, 8, one tc pulse; with SATURATE=1: 0, 0, tc pulse on each step.
3. Prescaler (PRESCALE=4): ena=1 continuously for 12 cycles -> count 0->1->2->3, stepping every 4th cycle. Then ena toggling 1,0,1,0... -> one step per 4 enabled cycles, with the prescaler holding while ena=0.
4. Load clamp and priority (MODULO=10): load=1 with load_val=15 -> count=9. load=1 and clear=1 together -> count=0. rst=1 with load=1 -> count=0, tc=0. load on a cycle where a step would occur -> count=load_val and no tc.
5. Compare and direction change: cmp_val=5, count up from 3 -> match high when count=5. Flip up_dn at 6 -> next step gives 5 and match is high again. Mid-prescale clear with PRESCALE=4 -> the next step needs a full 4 ena pulses.

Source files
------------

// File: rtl/mod_counter.sv
// Modulo-MODULO up/down counter with enable prescaler, load/clear, and
// wrap-or-saturate limits; emits a registered terminal-count pulse.
module mod_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULO   = 10,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clkf,
  input  logic             rst,
  input  logic             ena,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             match,
  output logic             at_max,
  output logic             at_min
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULO - 1);
  // One extra bit so MODULO == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             step;
  logic [WIDTH-1:0] load_clamped;

  assign step         = ena && (pre_q == PRE_LAST);
  assign load_clamped = ({1'b0, load_val} < MOD_EXT) ? load_val : CNT_MAX;

  always_comb begin
    cnt_d = cnt_q;
    pre_d = pre_q;
    tc_d  = 1'b0;
    if (clear) begin
      cnt_d = '0;
      pre_d = '0;
    end else if (load) begin
      cnt_d = load_clamped;
      pre_d = '0;
    end else if (step) begin
      pre_d = '0;
      if (up_dn) begin
        if (cnt_q == CNT_MAX) begin
          tc_d  = 1'b1;
          cnt_d = (SATURATE != 0) ? CNT_MAX : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          tc_d  = 1'b1;
          cnt_d = (SATURATE != 0) ? '0 : CNT_MAX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end else if (ena) begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clkf) begin
    if (rst) begin
      cnt_q <= '0;
      pre_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pre_q <= pre_d;
      tc_q  <= tc_d;
    end
  end

  assign count  = cnt_q;
  assign tc     = tc_q;
  assign match  = (cnt_q == cmp_val);
  assign at_max = (cnt_q == CNT_MAX);
  assign at_min = (cnt_q == '0);

endmodule
